// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic array: skews each lane by its index, inserts zero bubbles,
// and produces the per-lane done pulse delayed to cover the PE multiplier pipeline.
module systolic_skew_feeder #(
  parameter int WIDTH      = 16,
  parameter int LANES      = 4,
  parameter int DONE_DELAY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES-1:0]       out_done,
  output logic                   busy
);

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_DRAIN  = 1'b1
  } state_t;

  localparam int CW = $clog2(LANES + DONE_DELAY + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(LANES + DONE_DELAY);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic            accept_s;
  logic [LANES-1:0] lane_busy_s;

  assign accept_s = in_valid & in_ready;

  // State and drain counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ACCEPT;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state: hold off new beats until the last done pulse has left every lane
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_ACCEPT: begin
        if (accept_s && in_last) begin
          state_s = ST_DRAIN;
          cnt_s   = DRAIN_LOAD;
        end else begin
          state_s = ST_ACCEPT;
          cnt_s   = cnt_r;
        end
      end
      ST_DRAIN: begin
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = ST_ACCEPT;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_ACCEPT;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode of the state
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      ST_ACCEPT: in_ready = 1'b1;
      ST_DRAIN:  in_ready = 1'b0;
      default:   in_ready = 1'b0;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0]      data_r [0:i];
    logic [i:0]            valid_r;
    logic [i:0]            last_r;
    logic [DONE_DELAY-1:0] done_r;

    // Stage 0 is the common input register; stages 1..i form the lane skew
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) begin
          data_r[k] <= {WIDTH{1'b0}};
        end
        valid_r <= {(i+1){1'b0}};
        last_r  <= {(i+1){1'b0}};
        done_r  <= {DONE_DELAY{1'b0}};
      end else begin
        data_r[0]  <= accept_s ? in_data[i*WIDTH +: WIDTH] : {WIDTH{1'b0}};
        valid_r[0] <= accept_s;
        last_r[0]  <= accept_s & in_last;
        for (int k = 1; k <= i; k++) begin
          data_r[k]  <= data_r[k-1];
          valid_r[k] <= valid_r[k-1];
          last_r[k]  <= last_r[k-1];
        end
        done_r[0] <= last_r[i];
        for (int k = 1; k < DONE_DELAY; k++) begin
          done_r[k] <= done_r[k-1];
        end
      end
    end

    assign out_data[i*WIDTH +: WIDTH] = data_r[i];
    assign out_valid[i]               = valid_r[i];
    assign out_done[i]                = done_r[DONE_DELAY-1];
    assign lane_busy_s[i]             = |valid_r;
  end

  assign busy = (state_r == ST_DRAIN) | (|lane_busy_s);

endmodule
